// File: rtl/sar_search.sv
// ============================================================================
//  Module   : sar_search
//  Purpose  : Successive-approximation search of a WIDTH-bit value via an
//             external greater/equal/less comparator, MSB first.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sar_search #(
  parameter int WIDTH = 5,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             agtb,
  input  logic             aeqb,
  input  logic             altb,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [CW-1:0]    steps
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_TRY  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_msb     = c_one << (WIDTH-1);
  localparam logic [CW-1:0]    c_k_one   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    c_k_top   = CW'(WIDTH-1);

  state_t           r_state, w_state_n;
  logic [CW-1:0]    r_k, w_k_n;
  logic [WIDTH-1:0] w_trial_n, w_result_n;
  logic             w_busy_n, w_done_n, w_err_n, w_finish;
  logic [CW-1:0]    w_steps_n;
  logic [WIDTH-1:0] w_bit_k, w_bit_km1;
  logic             w_flags_ok;

  // Exactly one comparator flag must be asserted for the feedback to be trusted.
  assign w_flags_ok = (agtb ^ aeqb ^ altb) & ~(agtb & aeqb & altb);
  assign w_bit_k    = c_one << r_k;
  assign w_bit_km1  = w_bit_k >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      trial   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      err     <= 1'b0;
      steps   <= '0;
    end else begin
      r_state <= w_state_n;
      r_k     <= w_k_n;
      trial   <= w_trial_n;
      busy    <= w_busy_n;
      done    <= w_done_n;
      result  <= w_result_n;
      err     <= w_err_n;
      steps   <= w_steps_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_k_n      = r_k;
    w_trial_n  = trial;
    w_busy_n   = busy;
    w_done_n   = 1'b0;
    w_result_n = result;
    w_err_n    = err;
    w_steps_n  = steps;
    w_finish   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_trial_n = c_msb;
          w_k_n     = c_k_top;
          w_busy_n  = 1'b1;
          w_err_n   = 1'b0;
          w_steps_n = '0;
          w_state_n = S_TRY;
        end
      end
      S_TRY: begin
        w_steps_n = steps + c_k_one;
        if (!w_flags_ok) begin
          w_result_n = trial;
          w_err_n    = 1'b1;
          w_finish   = 1'b1;
        end else if (aeqb) begin
          w_result_n = trial;
          w_finish   = 1'b1;
        end else if (agtb) begin
          if (r_k != '0) begin
            w_trial_n = trial | w_bit_km1;
            w_k_n     = r_k - c_k_one;
          end else begin
            // Target above the largest reachable trial: feedback is inconsistent.
            w_result_n = trial;
            w_err_n    = 1'b1;
            w_finish   = 1'b1;
          end
        end else begin
          if (r_k != '0) begin
            w_trial_n = (trial & ~w_bit_k) | w_bit_km1;
            w_k_n     = r_k - c_k_one;
          end else begin
            w_result_n = trial & ~c_one;
            w_finish   = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    if (w_finish) begin
      w_done_n  = 1'b1;
      w_busy_n  = 1'b0;
      w_trial_n = '0;
      w_state_n = S_IDLE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sar_search.sv
// ============================================================================
//  Module   : tb_sar_search
//  Purpose  : Directed self-checking bench for sar_search with a comparator model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sar_search;

  logic       clk;
  logic       rst;
  logic       start;
  logic       agtb, aeqb, altb;
  logic [4:0] trial;
  logic       busy, done, err;
  logic [4:0] result;
  logic [2:0] steps;

  logic [4:0] tgt;
  logic       force_en;
  logic [4:0] force_trial;
  logic [2:0] force_vec;
  logic [2:0] w_model;

  int n_tests = 0;
  int n_fail  = 0;

  sar_search #(.WIDTH(5), .CW(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .agtb   (agtb),
    .aeqb   (aeqb),
    .altb   (altb),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .steps  (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator: a = hidden target, b = trial; optional flag override on one trial.
  assign w_model = {tgt > trial, tgt == trial, tgt < trial};
  assign {agtb, aeqb, altb} = (force_en && trial == force_trial) ? force_vec : w_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives start, follows trials, checks completion.
  task automatic search(input string name, input logic [4:0] t, input logic [24:0] trs,
                        input int ntr, input logic [4:0] r_exp, input logic e_exp,
                        input logic [2:0] s_exp, input bit hold);
    int edges = 0;
    tgt   = t;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    while (!done && edges < 20) begin
      check({name, "_busy"}, 32'(busy), 32'd1);
      if (edges < ntr) check({name, "_trial"}, 32'(trial), 32'(trs[edges*5 +: 5]));
      @(negedge clk);
      edges++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_latency"}, 32'(edges), 32'(s_exp));
    check({name, "_result"}, 32'(result), 32'(r_exp));
    check({name, "_err"}, 32'(err), 32'(e_exp));
    check({name, "_steps"}, 32'(steps), 32'(s_exp));
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_trial_end"}, 32'(trial), 32'd0);
    if (!hold) begin
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
      check({name, "_result_hold"}, 32'(result), 32'(r_exp));
    end
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; tgt = '0;
    force_en = 1'b0; force_trial = '0; force_vec = '0;
    repeat (2) @(negedge clk);
    check("rst_trial", 32'(trial), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_err", 32'(err), 0);
    check("rst_steps", 32'(steps), 0);
    rst = 1'b0;
    @(negedge clk);

    search("t13", 5'd13, {5'd13, 5'd14, 5'd12, 5'd8, 5'd16}, 5, 5'd13, 1'b0, 3'd5, 1'b0);
    search("t16", 5'd16, {20'd0, 5'd16}, 1, 5'd16, 1'b0, 3'd1, 1'b0);
    search("t31", 5'd31, {5'd31, 5'd30, 5'd28, 5'd24, 5'd16}, 5, 5'd31, 1'b0, 3'd5, 1'b0);
    search("t0", 5'd0, {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}, 5, 5'd0, 1'b0, 3'd5, 1'b0);
    search("t1", 5'd1, {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}, 5, 5'd1, 1'b0, 3'd5, 1'b0);

    // Both gt and lt asserted on the second compare.
    force_en = 1'b1; force_trial = 5'd24; force_vec = 3'b101;
    search("bad_flags", 5'd20, {15'd0, 5'd24, 5'd16}, 2, 5'd24, 1'b1, 3'd2, 1'b0);
    // Greater-than reported at the last bit position.
    force_trial = 5'd13; force_vec = 3'b100;
    search("gt_k0", 5'd13, {5'd13, 5'd14, 5'd12, 5'd8, 5'd16}, 5, 5'd13, 1'b1, 3'd5, 1'b0);
    force_en = 1'b0;

    // Reset asserted across the third compare.
    tgt = 5'd13; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_trial3", 32'(trial), 32'd12);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_busy", 32'(busy), 0);
    check("mid_trial", 32'(trial), 0);
    check("mid_result", 32'(result), 0);
    check("mid_err", 32'(err), 0);
    check("mid_steps", 32'(steps), 0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen_done |= done;
      @(negedge clk);
    end
    check("mid_no_done", 32'(seen_done), 0);
    search("post_rst", 5'd13, {5'd13, 5'd14, 5'd12, 5'd8, 5'd16}, 5, 5'd13, 1'b0, 3'd5, 1'b0);

    // start held high: ignored while busy, re-accepted in the done cycle.
    search("hold_a", 5'd9, {5'd9, 5'd10, 5'd12, 5'd8, 5'd16}, 5, 5'd9, 1'b0, 3'd5, 1'b1);
    search("hold_b", 5'd9, {5'd9, 5'd10, 5'd12, 5'd8, 5'd16}, 5, 5'd9, 1'b0, 3'd5, 1'b1);
    start = 1'b0;
    search("hold_c", 5'd9, {5'd9, 5'd10, 5'd12, 5'd8, 5'd16}, 5, 5'd9, 1'b0, 3'd5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
